am_radio_watchdog: RTL and testbench

//  Heartbeat watchdog for the AM-radio FPGA control path. A 32-bit counter advances every

---
 rtl/am_radio_watchdog.sv | 79 +++++++
 tb/tb_am_radio_watchdog.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/am_radio_watchdog.sv
// Heartbeat watchdog: counts enabled cycles between kicks, flags a warning,
// latches a sticky timeout and drives a fixed-length force_reset pulse.
module am_radio_watchdog #(
  parameter longint unsigned TIMEOUT_CYCLES     = 50_000_000,
  parameter longint unsigned WARN_CYCLES        = 40_000_000,
  parameter int unsigned     RESET_PULSE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        heartbeat,
  output logic        force_reset,
  output logic        warning,
  output logic        triggered,
  output logic [31:0] count
);

  if (TIMEOUT_CYCLES >= 64'h1_0000_0000) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit in 32 bits");
  end
  if (WARN_CYCLES < 1 || WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_warn
    $error("WARN_CYCLES must satisfy 1 <= WARN_CYCLES < TIMEOUT_CYCLES");
  end
  if (RESET_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("RESET_PULSE_CYCLES must be at least 1");
  end

  // Pulse counter holds the number of high cycles still owed after the current one.
  localparam int PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(RESET_PULSE_CYCLES - 1);
  localparam logic [32:0]   TIMEOUT_W  = 33'(TIMEOUT_CYCLES);
  localparam logic [32:0]   WARN_W     = 33'(WARN_CYCLES);

  logic [31:0]   count_reg;
  logic          warning_reg;
  logic          triggered_reg;
  logic          force_reset_reg;
  logic [PW-1:0] pulse_cnt_reg;
  logic [32:0]   count_inc;

  // Widened increment so the comparisons never see a wrapped value.
  assign count_inc = {1'b0, count_reg} + 33'd1;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      count_reg       <= '0;
      warning_reg     <= 1'b0;
      triggered_reg   <= 1'b0;
      force_reset_reg <= 1'b0;
      pulse_cnt_reg   <= '0;
    end else begin
      if (pulse_cnt_reg != '0) begin
        pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
      end else begin
        force_reset_reg <= 1'b0;
      end

      if (heartbeat) begin
        count_reg     <= '0;
        warning_reg   <= 1'b0;
        triggered_reg <= 1'b0;
      end else if (!triggered_reg) begin
        count_reg   <= count_inc[31:0];
        warning_reg <= (count_inc >= WARN_W);
        if (count_inc == TIMEOUT_W) begin
          triggered_reg   <= 1'b1;
          force_reset_reg <= 1'b1;
          pulse_cnt_reg   <= PULSE_LOAD;
        end
      end
    end
  end

  assign count       = count_reg;
  assign warning     = warning_reg;
  assign triggered   = triggered_reg;
  assign force_reset = force_reset_reg;

endmodule

// File: tb/tb_am_radio_watchdog.sv
// Directed + random stimulus for am_radio_watchdog with a queued reference model
// (TIMEOUT=8, WARN=6, PULSE=4).
module tb_am_radio_watchdog;

  localparam int T = 8;
  localparam int W = 6;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        heartbeat = 1'b0;
  logic        force_reset;
  logic        warning;
  logic        triggered;
  logic [31:0] count;

  int checks = 0;
  int failures = 0;

  am_radio_watchdog #(
    .TIMEOUT_CYCLES(T),
    .WARN_CYCLES(W),
    .RESET_PULSE_CYCLES(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .heartbeat(heartbeat),
    .force_reset(force_reset),
    .warning(warning),
    .triggered(triggered),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [34:0] v;
  } exp_t;

  exp_t sb[$];

  // Reference model: m_pl is the number of edges force_reset is still owed.
  int m_cnt = 0;
  bit m_warn = 0;
  bit m_trig = 0;
  int m_pl = 0;

  task automatic model_update(input logic r, input logic e, input logic h);
    if (r || !e) begin
      m_cnt = 0; m_warn = 0; m_trig = 0; m_pl = 0;
    end else begin
      if (m_pl > 0) m_pl--;
      if (h) begin
        m_cnt = 0; m_warn = 0; m_trig = 0;
      end else if (!m_trig) begin
        m_cnt++;
        m_warn = (m_cnt >= W);
        if (m_cnt == T) begin
          m_trig = 1;
          m_pl = P;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic h, input string tag);
    exp_t x;
    rst = r; enable = e; heartbeat = h;
    model_update(r, e, h);
    x.tag = tag;
    x.v = {(m_pl > 0), m_warn, m_trig, 32'(m_cnt)};
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert ({force_reset, warning, triggered, count} === x.v) else begin
      failures++;
      $error("FAIL %s got={fr,w,t,cnt}=%h exp=%h", x.tag, {force_reset, warning, triggered, count}, x.v);
    end
    $display("step %-6s rst=%b en=%b hb=%b -> fr=%b w=%b t=%b cnt=%0d", tag, r, e, h,
             force_reset, warning, triggered, count);
  endtask

  task automatic check_lit(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, "rst");
    check_lit("rst_cnt", count, 0);

    // 1: run to timeout and beyond the pulse
    for (int i = 1; i <= 14; i++) step(0, 1, 0, "run");
    check_lit("sat_cnt", count, 8);
    check_lit("pulse_done", {31'd0, force_reset}, 0);
    check_lit("trig_sticky", {31'd0, triggered}, 1);

    // 2: kick at 5, then kick every 7 cycles
    step(1, 0, 0, "rst");
    for (int i = 0; i < 5; i++) step(0, 1, 0, "cnt5");
    step(0, 1, 1, "kick");
    check_lit("kick_cnt", count, 0);
    for (int i = 0; i < 100; i++) step(0, 1, (i % 7 == 6), "kick7");
    check_lit("kick7_notrig", {31'd0, triggered}, 0);

    // 3: reset with enable low mid-count
    for (int i = 0; i < 5; i++) step(0, 1, 0, "cnt");
    step(1, 0, 0, "rstmid");
    step(0, 1, 0, "after");
    check_lit("after_cnt", count, 1);

    // 4: disarmed
    for (int i = 0; i < 20; i++) step(0, 0, 0, "dis");

    // 5: kick during pulse, then a second timeout
    step(1, 0, 0, "rst");
    for (int i = 0; i < 8; i++) step(0, 1, 0, "trig");
    step(0, 1, 1, "hbpul");
    check_lit("hb_pulse_fr", {31'd0, force_reset}, 1);
    for (int i = 0; i < 13; i++) step(0, 1, 0, "retrig");

    // 6: reset mid pulse
    step(1, 0, 0, "rst");
    for (int i = 0; i < 9; i++) step(0, 1, 0, "trig");
    step(1, 1, 0, "rstpul");
    check_lit("rst_pulse_fr", {31'd0, force_reset}, 0);

    // Random mix of kicks, disables and resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 11) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
